// File: rtl/imem_uart_loader_if.sv
// IMEM write port bundle between the serial loader
// and the instruction memory.
interface imem_uart_loader_if #(
  parameter int PC_WIDTH  = 12,
  parameter int OP_LENGTH = 32
);
  logic                 imem_we;
  logic [PC_WIDTH-1:0]  imem_addr;
  logic [OP_LENGTH-1:0] imem_wdata;

  modport master (
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    input imem_we,
    input imem_addr,
    input imem_wdata
  );
endinterface

// File: rtl/imem_uart_loader.sv
// UART 8N1 boot loader: fills IMEM with an image
// and holds the core in reset until it is complete.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PC_WIDTH     = 12,
  parameter int OP_LENGTH    = 32
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               uart_rx,
  imem_uart_loader_if.master imem,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    WAIT_HDR, CNT_LO, CNT_HI, WORD, DONE
  } ld_state_t;

  logic            rx_s1;
  logic            rx_s2;
  logic            rx_d;

  rx_state_t       rx_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            brk;
  logic            byte_valid;
  logic            rx_ferr;

  ld_state_t       ld_state;
  logic [15:0]     n_words;
  logic [15:0]     word_cnt;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_r;
  logic            last_wr;

  // Two-flop synchronizer plus one delay for edge detect
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Receiver: mid-bit sampling, LSB first, stop check
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      brk        <= 1'b0;
      byte_valid <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      rx_ferr    <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s2)
            rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (brk) begin
            if (rx_s2) begin
              brk      <= 1'b0;
              rx_state <= RX_IDLE;
            end
          end else if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s2) begin
              byte_valid <= 1'b1;
              rx_state   <= RX_IDLE;
            end else begin
              rx_ferr <= 1'b1;
              brk     <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Loader: header, count, word assembly, IMEM writes
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ld_state        <= WAIT_HDR;
      n_words         <= '0;
      word_cnt        <= '0;
      byte_idx        <= '0;
      asm_r           <= '0;
      last_wr         <= 1'b0;
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
      cpu_hold        <= 1'b1;
      load_done       <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      if (imem.imem_we) begin
        imem.imem_we   <= 1'b0;
        imem.imem_addr <= imem.imem_addr + PC_WIDTH'(4);
        if (last_wr) begin
          last_wr   <= 1'b0;
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
        end
      end
      if (rx_ferr) begin
        frame_err <= 1'b1;
        if (ld_state != DONE)
          ld_state <= WAIT_HDR;
      end else if (byte_valid) begin
        unique case (ld_state)
          WAIT_HDR, DONE: begin
            if (shreg == HDR) begin
              ld_state       <= CNT_LO;
              imem.imem_addr <= '0;
              byte_idx       <= '0;
              word_cnt       <= '0;
              frame_err      <= 1'b0;
              cpu_hold       <= 1'b1;
              load_done      <= 1'b0;
            end
          end
          CNT_LO: begin
            n_words[7:0] <= shreg;
            ld_state     <= CNT_HI;
          end
          CNT_HI: begin
            n_words[15:8] <= shreg;
            if ({shreg, n_words[7:0]} == 16'd0) begin
              ld_state  <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              ld_state <= WORD;
            end
          end
          WORD: begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem.imem_we    <= 1'b1;
              imem.imem_wdata <= {shreg, asm_r};
              if (word_cnt + 16'd1 == n_words) begin
                ld_state <= DONE;
                last_wr  <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 16'd1;
              end
            end else begin
              asm_r <= {shreg, asm_r[23:8]};
            end
          end
          default: ld_state <= WAIT_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboarded bench for imem_uart_loader: a 12-bit
// and a 4-bit address instance share one RX line.
module tb_imem_uart_loader;

  localparam int CPB = 4;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  logic sysclk;
  logic rst;
  logic uart_rx;

  logic cpu_hold12, load_done12, frame_err12;
  logic cpu_hold4, load_done4, frame_err4;

  imem_uart_loader_if #(.PC_WIDTH(12), .OP_LENGTH(32)) m12 ();
  imem_uart_loader_if #(.PC_WIDTH(4), .OP_LENGTH(32))  m4 ();

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB), .PC_WIDTH(12), .OP_LENGTH(32)
  ) dut12 (
    .sysclk    (sysclk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .imem      (m12.master),
    .cpu_hold  (cpu_hold12),
    .load_done (load_done12),
    .frame_err (frame_err12)
  );

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB), .PC_WIDTH(4), .OP_LENGTH(32)
  ) dut4 (
    .sysclk    (sysclk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .imem      (m4.master),
    .cpu_hold  (cpu_hold4),
    .load_done (load_done4),
    .frame_err (frame_err4)
  );

  int checks = 0;
  int errors = 0;

  wr_t q12[$];
  wr_t q4[$];

  bit nxt12 = 0, exl12 = 0;
  bit nxt4 = 0, exl4 = 0;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [11:0] a,
                         input logic [31:0] d,
                         input bit l);
    q12.push_back('{a, d, l});
    q4.push_back('{{8'h0, a[3:0]}, d, l});
  endtask

  // Monitor for the 12-bit instance
  always @(negedge sysclk) begin
    wr_t e;
    if (nxt12) begin
      nxt12 = 0;
      chk("status12_after_wr",
          {30'd0, cpu_hold12, load_done12},
          {30'd0, !exl12, exl12});
    end
    if (!rst && m12.imem_we === 1'b1) begin
      if (q12.size() == 0) begin
        chk("unexpected_wr12", {20'd0, m12.imem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = q12.pop_front();
        chk("wr12_addr", {20'd0, m12.imem_addr}, {20'd0, e.addr});
        chk("wr12_data", m12.imem_wdata, e.data);
        nxt12 = 1;
        exl12 = e.last;
      end
    end
  end

  // Monitor for the 4-bit instance
  always @(negedge sysclk) begin
    wr_t e;
    if (nxt4) begin
      nxt4 = 0;
      chk("status4_after_wr",
          {30'd0, cpu_hold4, load_done4},
          {30'd0, !exl4, exl4});
    end
    if (!rst && m4.imem_we === 1'b1) begin
      if (q4.size() == 0) begin
        chk("unexpected_wr4", {28'd0, m4.imem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = q4.pop_front();
        chk("wr4_addr", {28'd0, m4.imem_addr}, {20'd0, e.addr});
        chk("wr4_data", m4.imem_wdata, e.data);
        nxt4 = 1;
        exl4 = e.last;
      end
    end
  end

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop = 1'b1);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
    bit_time(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic chk_status(input string nm,
                            input logic h,
                            input logic d,
                            input logic f);
    chk(nm, {29'd0, cpu_hold12, load_done12, frame_err12},
        {29'd0, h, d, f});
    chk({nm, "_4"}, {29'd0, cpu_hold4, load_done4, frame_err4},
        {29'd0, h, d, f});
  endtask

  logic [31:0] w5 [5];

  initial begin
    w5[0] = 32'hA0B1C2D0;
    w5[1] = 32'hA0B1C2D1;
    w5[2] = 32'hA0B1C2D2;
    w5[3] = 32'hA0B1C2D3;
    w5[4] = 32'hA0B1C2D4;

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge sysclk);
    chk_status("reset_status", 1'b1, 1'b0, 1'b0);
    chk("reset_we", {31'd0, m12.imem_we}, 32'd0);
    chk("reset_addr", {20'd0, m12.imem_addr}, 32'd0);
    chk("reset_wdata", m12.imem_wdata, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge sysclk);

    // two-word image
    push_wr(12'h000, 32'h00000013, 0);
    push_wr(12'h004, 32'h00100093, 1);
    send_hdr(16'd2);
    send_word(32'h00000013);
    send_word(32'h00100093);
    chk_status("t1_done", 1'b0, 1'b1, 1'b0);
    chk("t1_addr", {20'd0, m12.imem_addr}, 32'h008);

    // junk then empty image
    send_byte(8'h00);
    send_byte(8'hFF);
    chk_status("t2_junk_ignored", 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    chk_status("t2_after_hdr", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    chk_status("t2_empty_done", 1'b0, 1'b1, 1'b0);

    // framing error mid-word, then recovery
    send_hdr(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b0);
    chk_status("t3_ferr", 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    chk_status("t3_hdr_clears", 1'b1, 1'b0, 1'b0);
    push_wr(12'h000, 32'hEFBEADDE, 1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hEFBEADDE);
    chk_status("t3_done", 1'b0, 1'b1, 1'b0);

    // one-cycle glitch while idle
    @(negedge sysclk);
    uart_rx = 1'b0;
    @(negedge sysclk);
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge sysclk);
    chk_status("t4_glitch", 1'b0, 1'b1, 1'b0);
    chk("t4_wdata", m12.imem_wdata, 32'hEFBEADDE);
    chk("t4_addr", {20'd0, m12.imem_addr}, 32'h004);

    // five words: 4-bit instance wraps to 0
    for (int i = 0; i < 5; i++)
      push_wr(12'(4 * i), w5[i], i == 4);
    send_hdr(16'd5);
    for (int i = 0; i < 5; i++) send_word(w5[i]);
    chk_status("t5_done", 1'b0, 1'b1, 1'b0);
    chk("t5_addr12", {20'd0, m12.imem_addr}, 32'h014);
    chk("t5_addr4", {28'd0, m4.imem_addr}, 32'h4);

    // reset during the 3rd byte of a word
    send_hdr(16'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_status("t6_async_rst", 1'b1, 1'b0, 1'b0);
    chk("t6_rst_wdata", m12.imem_wdata, 32'd0);
    chk("t6_rst_addr", {20'd0, m12.imem_addr}, 32'd0);
    chk("t6_rst_we", {31'd0, m12.imem_we}, 32'd0);
    uart_rx = 1'b1;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (4) @(negedge sysclk);
    push_wr(12'h000, 32'h12345678, 1);
    send_hdr(16'd1);
    send_word(32'h12345678);
    chk_status("t6_done", 1'b0, 1'b1, 1'b0);

    repeat (8) @(negedge sysclk);
    chk("q12_drained", q12.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Serial boot loader; the write side of the core's instruction memory, which the core only reads.
- Receives a program image over a UART 8N1 line, assembles 32-bit words and writes them into instruction memory through a single write port.
- Holds the core in reset until the image is complete.
- Sits at top level between the board RX pin, the IMEM write port and the core reset input.

Parameters:
- CLKS_PER_BIT, 868, sysclk cycles per UART bit (100 MHz / 115200); minimum 4
- PC_WIDTH, 12, IMEM byte-address width
- OP_LENGTH, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
- sysclk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- uart_rx  in  1  serial line, idle high, asynchronous to sysclk
- imem_we  out  1  IMEM write strobe, one-cycle pulse
- imem_addr  out  PC_WIDTH  IMEM byte address, word-aligned (bits [1:0] = 0)
- imem_wdata  out  OP_LENGTH  word to write
- cpu_hold  out  1  core reset request; 1 = core held in reset
- load_done  out  1  image fully written
- frame_err  out  1  sticky: a framing error occurred during the current load

Behaviour:
- Reset values: cpu_hold=1, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, frame_err=0. All internal state is cleared; the RX synchronizer flops reset to 1.
- RX front end:
  - uart_rx passes through a 2-flop synchronizer.
  - Receiver states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge.
  - START: at CLKS_PER_BIT/2 (integer division), if the line is high it is a glitch → IDLE; else → DATA.
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample after one more CLKS_PER_BIT. Line high → one-cycle byte_valid with the byte. Line low → byte discarded, frame_err set, receiver waits for the line high before returning to IDLE.
- Image format: header 0xA5, then N as 2 bytes little-endian, then N words of 4 bytes each, little-endian.
- Loader FSM states: WAIT_HDR, CNT_LO, CNT_HI, WORD, DONE.
  - WAIT_HDR: bytes other than 0xA5 are ignored. 0xA5 → CNT_LO, imem_addr←0, byte index←0, frame_err←0.
  - CNT_LO: capture the low byte of N.
  - CNT_HI: capture the high byte of N. If N==0 → DONE, else → WORD.
  - WORD: shift each byte into the assembly register at position byte_index*8. On the 4th byte, in the next cycle: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = current address. imem_addr increments by 4 in the cycle after the pulse, wrapping modulo 2^PC_WIDTH. Words are counted; after word N → DONE.
  - DONE: load_done=1, cpu_hold=0 (both registered, taking effect the cycle after the last imem_we). A further 0xA5 starts a new load: cpu_hold=1, load_done=0 in the next cycle, → CNT_LO. Other bytes are ignored.
- A framing error in any state other than DONE aborts the load: → WAIT_HDR, cpu_hold stays 1, frame_err stays 1 until the next 0xA5 header. A framing error in DONE sets frame_err only; cpu_hold stays 0.
- imem_wdata holds the last written word between pulses.
- rst asserted mid-byte or mid-image aborts immediately to reset values. A partially written image is not cleared from IMEM.

Test Plan:
1. CLKS_PER_BIT=4. Send A5 02 00 13 00 00 00 93 00 10 00 → imem_we pulses twice: (addr 0x000, 0x00000013) then (addr 0x004, 0x00100093). cpu_hold falls and load_done rises 1 cycle after the 2nd pulse.
2. Send 00 FF A5 00 00 → the first two bytes are ignored, no imem_we occurs, load_done=1 and cpu_hold=0 right after the count high byte.
3. Send A5 01 00 11 22, then one byte with a stop bit of 0 → frame_err=1, no imem_we, cpu_hold=1. A following A5 01 00 DE AD BE EF → frame_err cleared at the header, write of 0xEFBEADDE at 0x000.
4. A 1-cycle low glitch on uart_rx while idle → no byte_valid, all outputs unchanged.
5. With PC_WIDTH=4, load 5 words → addresses written in order 0x0, 0x4, 0x8, 0xC, 0x0 (wrap).
6. Assert rst during the 3rd byte of a word → outputs return to reset values asynchronously. A subsequent full 1-word image loads correctly at addr 0.
